scaffold_fn_mul_arbiter: RTL and testbench

Round-robin scheduler that shares one 32x32->64 unsigned multiplier instance (pipeline depth MUL_LAT, 0 = combinational) among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready channels, issues at most one operation per cycle into the multiplier, and tracks ownership through the multiplier pipeline. It returns each 64-bit product to its owner over a per-requester valid/ready response channel. It sits between HLS-generated function blocks and the shared multiplier.

---
 rtl/scaffold_fn_mul_arbiter.sv | 119 +++++++++++
 tb/tb_scaffold_fn_mul_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/scaffold_fn_mul_arbiter.sv
// Round-robin scheduler sharing one 32x32->64 multiplier among NUM_REQ
// requesters, with per-requester result slots and ownership tag pipe.
module scaffold_fn_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 0,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*64-1:0] rsp_data,
  output logic [31:0]           mul_din0,
  output logic [31:0]           mul_din1,
  output logic                  mul_ce,
  input  logic [63:0]           mul_dout,
  output logic [ID_W:0]         inflight
);

  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] busy_nxt;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_nxt;
  logic [NUM_REQ-1:0] rsp_hs;
  logic [ID_W-1:0]    rr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic [ID_W:0]      idx;
  logic [ID_W:0]      cnt;
  logic [MUL_LAT:0]   stg_vld;
  logic [ID_W-1:0]    stg_tag [MUL_LAT+1];
  logic [63:0]        result  [NUM_REQ];
  logic               fin_vld;
  logic [ID_W-1:0]    fin_tag;

  assign elig    = req_valid & ~busy;
  assign rsp_hs  = rsp_valid & rsp_ready;
  assign fin_vld = stg_vld[MUL_LAT];
  assign fin_tag = stg_tag[MUL_LAT];
  assign mul_ce  = |stg_vld;

  // Scan downward so the eligible requester nearest rr wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = {1'b0, rr} + (ID_W+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
  end

  assign gnt       = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
  assign req_ready = ap_rst ? '0 : gnt;
  assign busy_nxt  = (busy | gnt) & ~rsp_hs;

  always_comb begin
    rsp_nxt = rsp_valid & ~rsp_hs;
    if (fin_vld) rsp_nxt[fin_tag] = 1'b1;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      cnt = cnt + (ID_W+1)'(busy_nxt[i]);
  end

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_data[64*i +: 64] = result[i];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      busy      <= '0;
      rr        <= '0;
      rsp_valid <= '0;
      stg_vld   <= '0;
      mul_din0  <= '0;
      mul_din1  <= '0;
      inflight  <= '0;
      for (int k = 0; k <= MUL_LAT; k++) stg_tag[k] <= '0;
    end else begin
      busy       <= busy_nxt;
      rsp_valid  <= rsp_nxt;
      inflight   <= cnt;
      stg_vld[0] <= gnt_vld;
      if (gnt_vld) begin
        stg_tag[0] <= gnt_id;
        mul_din0   <= req_a[32*gnt_id +: 32];
        mul_din1   <= req_b[32*gnt_id +: 32];
        rr         <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0
                                                    : gnt_id + ID_W'(1);
      end
      for (int k = 1; k <= MUL_LAT; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_tag[k] <= stg_tag[k-1];
      end
    end
  end

  // Slot contents are only meaningful under rsp_valid, so no reset.
  always_ff @(posedge ap_clk) begin
    if (fin_vld) result[fin_tag] <= mul_dout;
  end

endmodule

// File: tb/tb_scaffold_fn_mul_arbiter.sv
// Scoreboard bench for scaffold_fn_mul_arbiter with a 3-stage
// multiplier model and a round-robin reference model.
module tb_scaffold_fn_mul_arbiter;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*64-1:0] rsp_data;
  logic [31:0]     mul_din0;
  logic [31:0]     mul_din1;
  logic            mul_ce;
  logic [63:0]     mul_dout;
  logic [IW:0]     inflight;

  always #5 clk = ~clk;

  scaffold_fn_mul_arbiter #(.NUM_REQ(N), .MUL_LAT(L), .ID_W(IW)) dut (
    .ap_clk(clk), .ap_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_ce(mul_ce),
    .mul_dout(mul_dout), .inflight(inflight)
  );

  logic [63:0] mp [L];
  always @(posedge clk) begin
    if (mul_ce) begin
      mp[0] <= {32'b0, mul_din0} * {32'b0, mul_din1};
      for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
    end
  end
  assign mul_dout = mp[L-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  exp_t        exq [N][$];
  int          hs_cnt [N];
  int          seen [N];
  logic [N-1:0] outst;
  int          ptr;
  logic [L:0]  hist;
  int          win;
  logic [N-1:0] want;

  initial begin
    for (int i = 0; i < N; i++) begin
      hs_cnt[i] = 0;
      seen[i]   = 0;
    end
  end

  // Request side: reference arbitration, inflight, mul_ce, enqueue.
  always @(negedge clk) begin
    if (rst) begin
      outst = '0;
      ptr   = 0;
      hist  = '0;
      for (int i = 0; i < N; i++) exq[i].delete();
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (win < 0 && req_valid[j] && !outst[j]) win = j;
      end
      want = (win < 0) ? '0 : N'(1) << win;
      chk("req_ready", 64'(req_ready), 64'(want));
      chk("inflight", 64'(inflight), 64'($countones(outst)));
      chk("mul_ce", 64'(mul_ce), 64'(|hist));
      hist = {hist[L-1:0], |(req_valid & req_ready)};
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exq[i].push_back('{d: {32'b0, req_a[32*i +: 32]} *
                                {32'b0, req_b[32*i +: 32]},
                             due: cyc + 2 + L});
          outst[i] = 1'b1;
          hs_cnt[i]++;
          ptr = (i + 1) % N;
        end
        if (rsp_valid[i] && rsp_ready[i]) outst[i] = 1'b0;
      end
    end
  end

  // Response side: latency, routing, stability, pop on accept.
  logic [N-1:0] pv = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          if (exq[i].size() == 0) begin
            chk("rsp_spurious", 64'(rsp_valid[i]), 64'd0);
          end else begin
            if (!pv[i]) chk("rsp_latency", 64'(cyc), 64'(exq[i][0].due));
            chk("rsp_data", rsp_data[64*i +: 64], exq[i][0].d);
            if (rsp_ready[i]) void'(exq[i].pop_front());
          end
        end
      end
      pv = rsp_valid;
    end
  end

  function automatic logic [31:0] rand_op();
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // opm: 0 random (may drop), 1 a=i+1 b=0x10, 2 all-ones
  task automatic drive(input logic [N-1:0] w, input int opm,
                       input logic [N-1:0] rr_in);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && hs_cnt[i] == seen[i] &&
          !(opm == 0 && $urandom_range(15) == 0)) continue;
      seen[i]      = hs_cnt[i];
      req_valid[i] = w[i];
      case (opm)
        1: begin
          req_a[32*i +: 32] = 32'(i + 1);
          req_b[32*i +: 32] = 32'h10;
        end
        2: begin
          req_a[32*i +: 32] = 32'hFFFF_FFFF;
          req_b[32*i +: 32] = 32'hFFFF_FFFF;
        end
        default: begin
          req_a[32*i +: 32] = rand_op();
          req_b[32*i +: 32] = rand_op();
        end
      endcase
    end
    rsp_ready = rr_in;
  endtask

  initial begin
    int left;
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_mul_din0", 64'(mul_din0), 64'd0);
    chk("rst_mul_ce", 64'(mul_ce), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #3 rst = 1'b0;

    repeat (12) drive(4'b0001, 2, 4'b1111);
    repeat (40) drive(4'b1111, 1, 4'b1111);
    repeat (20) drive(N'($urandom) | 4'b0100, 0, 4'b1011);
    repeat (300) drive(N'($urandom), 0, N'($urandom));

    repeat (6) drive(4'b1111, 0, 4'b1111);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_inflight", 64'(inflight), 64'd0);
    chk("arst_mul_ce", 64'(mul_ce), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    drive(4'b0001, 2, 4'b1111);
    repeat (8) drive(4'b0000, 2, 4'b1111);
    repeat (3) drive(4'b1000, 2, 4'b1111);
    repeat (100) drive(N'($urandom), 0, N'($urandom));

    left = 200;
    while (left > 0) begin
      int tot;
      drive(4'b0000, 0, 4'b1111);
      tot = 0;
      for (int i = 0; i < N; i++) tot += exq[i].size();
      if (tot == 0 && req_valid == '0) break;
      left--;
    end
    begin
      int tot;
      tot = 0;
      for (int i = 0; i < N; i++) tot += exq[i].size();
      chk("drain_pending", 64'(tot), 64'd0);
    end
    chk("drain_inflight", 64'(inflight), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

endmodule
